// File: rtl/calc1.sv
// calc1: four independent unsigned 32-bit calculator ports (command+op1, then op2).
// Latency: result registered on the edge that latches op2, held one cycle; no backpressure.
module calc1_port (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:3]  cmd,
  input  logic [0:31] data,
  output logic [0:31] out_data,
  output logic [0:1]  out_resp
);
  typedef enum logic [1:0] {IDLE, OP2, RESP} state_t;

  localparam logic [0:1] RESP_NONE = 2'd0;
  localparam logic [0:1] RESP_OK   = 2'd1;
  localparam logic [0:1] RESP_ERR  = 2'd2;

  state_t      state;
  logic [0:3]  cmd_q;
  logic [0:31] op1_q;
  logic [0:32] sum;
  logic [0:31] res_data;
  logic [0:1]  res_resp;

  // Bit 0 of the 33-bit sum is the carry out of the operand MSB.
  assign sum = {1'b0, op1_q} + {1'b0, data};

  always_comb begin
    res_data = '0;
    res_resp = RESP_ERR;
    case (cmd_q)
      4'd1: if (!sum[0]) begin
        res_resp = RESP_OK;
        res_data = sum[1:32];
      end
      4'd2: if (data <= op1_q) begin
        res_resp = RESP_OK;
        res_data = op1_q - data;
      end
      4'd5: begin
        res_resp = RESP_OK;
        res_data = op1_q << data[27:31];
      end
      4'd6: begin
        res_resp = RESP_OK;
        res_data = op1_q >> data[27:31];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cmd_q    <= '0;
      op1_q    <= '0;
      out_data <= '0;
      out_resp <= RESP_NONE;
    end else begin
      out_data <= '0;
      out_resp <= RESP_NONE;
      case (state)
        OP2: begin
          out_data <= res_data;
          out_resp <= res_resp;
          state    <= RESP;
        end
        // IDLE and RESP both accept a new request, which allows back-to-back use.
        default: begin
          if (cmd != 4'd0) begin
            cmd_q <= cmd;
            op1_q <= data;
            state <= OP2;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// calc1 top: four calc1_port engines sharing clock and a 7-bit synchronous reset.
// Latency: two request cycles, response on the op2 edge; ports never stall or interact.
module calc1 (
  input  logic        c_clk,
  input  logic [1:7]  reset,
  input  logic [0:3]  req1_cmd_in,
  input  logic [0:31] req1_data_in,
  input  logic [0:3]  req2_cmd_in,
  input  logic [0:31] req2_data_in,
  input  logic [0:3]  req3_cmd_in,
  input  logic [0:31] req3_data_in,
  input  logic [0:3]  req4_cmd_in,
  input  logic [0:31] req4_data_in,
  output logic [0:31] out_data1,
  output logic [0:1]  out_resp1,
  output logic [0:31] out_data2,
  output logic [0:1]  out_resp2,
  output logic [0:31] out_data3,
  output logic [0:1]  out_resp3,
  output logic [0:31] out_data4,
  output logic [0:1]  out_resp4
);
  logic rst;

  assign rst = |reset;

  calc1_port u_port1 (.clk(c_clk), .rst(rst), .cmd(req1_cmd_in), .data(req1_data_in),
                      .out_data(out_data1), .out_resp(out_resp1));
  calc1_port u_port2 (.clk(c_clk), .rst(rst), .cmd(req2_cmd_in), .data(req2_data_in),
                      .out_data(out_data2), .out_resp(out_resp2));
  calc1_port u_port3 (.clk(c_clk), .rst(rst), .cmd(req3_cmd_in), .data(req3_data_in),
                      .out_data(out_data3), .out_resp(out_resp3));
  calc1_port u_port4 (.clk(c_clk), .rst(rst), .cmd(req4_cmd_in), .data(req4_data_in),
                      .out_data(out_data4), .out_resp(out_resp4));
endmodule

// File: tb/tb_calc1.sv
// Self-checking bench for calc1: directed and randomized requests on all four ports
// compared against a transaction-level arithmetic model.
module tb_calc1;
  logic        c_clk = 1'b0;
  logic [1:7]  reset;
  logic [0:3]  req_cmd  [4];
  logic [0:31] req_data [4];
  logic [0:31] out_data [4];
  logic [0:1]  out_resp [4];

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [3:0]  cmd_v [4];
  logic [31:0] op1_v [4];
  logic [31:0] op2_v [4];
  logic [31:0] rsp_data  [4];
  logic [1:0]  rsp_resp  [4];
  logic [31:0] post_data [4];
  logic [1:0]  post_resp [4];

  calc1 dut (
    .c_clk(c_clk), .reset(reset),
    .req1_cmd_in(req_cmd[0]), .req1_data_in(req_data[0]),
    .req2_cmd_in(req_cmd[1]), .req2_data_in(req_data[1]),
    .req3_cmd_in(req_cmd[2]), .req3_data_in(req_data[2]),
    .req4_cmd_in(req_cmd[3]), .req4_data_in(req_data[3]),
    .out_data1(out_data[0]), .out_resp1(out_resp[0]),
    .out_data2(out_data[1]), .out_resp2(out_resp[1]),
    .out_data3(out_data[2]), .out_resp3(out_resp[2]),
    .out_data4(out_data[3]), .out_resp4(out_resp[3])
  );

  always #5 c_clk = ~c_clk;

  // Returns {resp, data} for one completed request, from plain 64-bit arithmetic.
  function automatic logic [33:0] model(input logic [3:0] cmd, input logic [31:0] a,
                                        input logic [31:0] b);
    longint unsigned x, y, r;
    x = 64'(a);
    y = 64'(b);
    case (cmd)
      4'd1: begin
        r = x + y;
        if (r > 64'h0000_0000_FFFF_FFFF) return {2'd2, 32'd0};
        return {2'd1, 32'(r)};
      end
      4'd2: begin
        if (y > x) return {2'd2, 32'd0};
        r = x - y;
        return {2'd1, 32'(r)};
      end
      4'd5: begin
        r = (x << (y % 32)) & 64'h0000_0000_FFFF_FFFF;
        return {2'd1, 32'(r)};
      end
      4'd6: begin
        r = x >> (y % 32);
        return {2'd1, 32'(r)};
      end
      default: return {2'd2, 32'd0};
    endcase
  endfunction

  function automatic logic [3:0] rand_cmd();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0, 1: return 4'd1;
      2, 3: return 4'd2;
      4, 5: return 4'd5;
      6, 7: return 4'd6;
      default: return 4'($urandom_range(3, 15));
    endcase
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 40));
      2: return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      default: return $urandom >> $urandom_range(0, 31);
    endcase
  endfunction

  task automatic idle_port(input int p);
    req_cmd[p]  = 4'd0;
    req_data[p] = $urandom;
  endtask

  task automatic drive_op1(input logic [3:0] mask);
    for (int p = 0; p < 4; p++)
      if (mask[p]) begin
        req_cmd[p]  = cmd_v[p];
        req_data[p] = op1_v[p];
      end else idle_port(p);
  endtask

  // The command lines carry junk during the op2 cycle; the port must ignore them.
  task automatic drive_op2(input logic [3:0] mask);
    for (int p = 0; p < 4; p++)
      if (mask[p]) begin
        req_cmd[p]  = 4'($urandom_range(0, 15));
        req_data[p] = op2_v[p];
      end else idle_port(p);
  endtask

  task automatic snap(input bit post);
    for (int p = 0; p < 4; p++)
      if (post) begin
        post_data[p] = out_data[p];
        post_resp[p] = out_resp[p];
      end else begin
        rsp_data[p] = out_data[p];
        rsp_resp[p] = out_resp[p];
      end
  endtask

  task automatic run_txn(input logic [3:0] mask);
    drive_op1(mask);
    @(negedge c_clk);
    drive_op2(mask);
    @(negedge c_clk);
    snap(1'b0);
    for (int p = 0; p < 4; p++) idle_port(p);
    @(negedge c_clk);
    snap(1'b1);
  endtask

  task automatic test_reset();
    reset = 7'b100_0000;
    repeat (4) begin
      for (int p = 0; p < 4; p++) begin
        req_cmd[p]  = 4'($urandom_range(0, 15));
        req_data[p] = $urandom;
      end
      @(negedge c_clk);
      for (int p = 0; p < 4; p++) begin
        total_cnt++;
        if (out_resp[p] !== 2'd0 || out_data[p] !== 32'd0)
          $display("FAIL reset_hold p%0d: got resp=%0d data=%h want resp=0 data=0",
                   p + 1, out_resp[p], out_data[p]);
        else pass_cnt++;
      end
    end
    reset = '0;
    for (int p = 0; p < 4; p++) idle_port(p);
    repeat (2) begin
      @(negedge c_clk);
      for (int p = 0; p < 4; p++) begin
        total_cnt++;
        if (out_resp[p] !== 2'd0 || out_data[p] !== 32'd0)
          $display("FAIL reset_idle p%0d: got resp=%0d data=%h want resp=0 data=0",
                   p + 1, out_resp[p], out_data[p]);
        else pass_cnt++;
      end
      for (int p = 0; p < 4; p++) idle_port(p);
    end
  endtask

  task automatic test_reset_abort();
    for (int p = 0; p < 4; p++) begin
      cmd_v[p] = 4'd1;
      op1_v[p] = 32'd5;
      op2_v[p] = 32'd7;
    end
    drive_op1(4'hF);
    @(negedge c_clk);
    drive_op2(4'hF);
    reset = 7'b000_0001;
    @(negedge c_clk);
    reset = '0;
    for (int p = 0; p < 4; p++) idle_port(p);
    repeat (2) begin
      for (int p = 0; p < 4; p++) begin
        total_cnt++;
        if (out_resp[p] !== 2'd0 || out_data[p] !== 32'd0)
          $display("FAIL reset_abort p%0d: got resp=%0d data=%h want resp=0 data=0",
                   p + 1, out_resp[p], out_data[p]);
        else pass_cnt++;
      end
      @(negedge c_clk);
    end
  endtask

  task automatic test_add();
    logic [31:0] a_tab [3] = '{32'h0000_0001, 32'h1FFF_FFFF, 32'h0000_0000};
    logic [31:0] b_tab [3] = '{32'h1FFF_FFFF, 32'h1FFF_FFFF, 32'h0000_0000};
    logic [31:0] want  [3] = '{32'h2000_0000, 32'h3FFF_FFFE, 32'h0000_0000};
    for (int i = 0; i < 3; i++) begin
      cmd_v[0] = 4'd1;
      op1_v[0] = a_tab[i];
      op2_v[0] = b_tab[i];
      run_txn(4'b0001);
      total_cnt++;
      if (rsp_resp[0] !== 2'd1 || rsp_data[0] !== want[i])
        $display("FAIL add_%0d: got resp=%0d data=%h want resp=1 data=%h",
                 i, rsp_resp[0], rsp_data[0], want[i]);
      else pass_cnt++;
      total_cnt++;
      if (post_resp[0] !== 2'd0 || post_data[0] !== 32'd0)
        $display("FAIL add_%0d_one_cycle: got resp=%0d data=%h want resp=0 data=0",
                 i, post_resp[0], post_data[0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_overflow();
    for (int q = 0; q < 4; q++) begin
      cmd_v[q] = 4'd1;
      op1_v[q] = 32'hFFFF_FFFF;
      op2_v[q] = 32'd1;
      run_txn(4'(1 << q));
      for (int p = 0; p < 4; p++) begin
        total_cnt++;
        if (p == q) begin
          if (rsp_resp[p] !== 2'd2 || rsp_data[p] !== 32'd0)
            $display("FAIL overflow p%0d: got resp=%0d data=%h want resp=2 data=0",
                     p + 1, rsp_resp[p], rsp_data[p]);
          else pass_cnt++;
        end else begin
          if (rsp_resp[p] !== 2'd0 || rsp_data[p] !== 32'd0)
            $display("FAIL overflow_other p%0d (req on p%0d): got resp=%0d data=%h want resp=0 data=0",
                     p + 1, q + 1, rsp_resp[p], rsp_data[p]);
          else pass_cnt++;
        end
      end
    end
  endtask

  task automatic test_underflow_invalid();
    logic [3:0]  c_tab [6] = '{4'd2, 4'd3, 4'd4, 4'd7, 4'd12, 4'd15};
    logic [31:0] b_tab [6] = '{32'h0000_000F, 32'd1, 32'd2, 32'd1, 32'd3, 32'd1};
    for (int i = 0; i < 6; i++) begin
      cmd_v[1] = c_tab[i];
      op1_v[1] = 32'd1;
      op2_v[1] = b_tab[i];
      run_txn(4'b0010);
      total_cnt++;
      if (rsp_resp[1] !== 2'd2 || rsp_data[1] !== 32'd0)
        $display("FAIL err_cmd%0d: got resp=%0d data=%h want resp=2 data=0",
                 c_tab[i], rsp_resp[1], rsp_data[1]);
      else pass_cnt++;
    end
  endtask

  task automatic test_walking();
    logic [31:0] sr;
    int p;
    for (int k = 0; k <= 30; k++) begin
      p = k % 4;
      cmd_v[p] = 4'd1;
      op1_v[p] = 32'd1 << k;
      op2_v[p] = 32'd0;
      run_txn(4'(1 << p));
      total_cnt++;
      if (rsp_resp[p] !== 2'd1 || rsp_data[p] !== (32'd1 << k))
        $display("FAIL walk_add k=%0d: got resp=%0d data=%h want resp=1 data=%h",
                 k, rsp_resp[p], rsp_data[p], 32'd1 << k);
      else pass_cnt++;
    end
    for (int a = 1; a <= 31; a++) begin
      p = a % 4;
      cmd_v[p] = 4'd5;
      op1_v[p] = 32'd1;
      op2_v[p] = 32'(a);
      run_txn(4'(1 << p));
      total_cnt++;
      if (rsp_resp[p] !== 2'd1 || rsp_data[p] !== (32'd1 << a))
        $display("FAIL walk_shl a=%0d: got resp=%0d data=%h want resp=1 data=%h",
                 a, rsp_resp[p], rsp_data[p], 32'd1 << a);
      else pass_cnt++;
    end
    sr = 32'h8000_0000;
    for (int i = 0; i < 30; i++) begin
      p = i % 4;
      cmd_v[p] = 4'd6;
      op1_v[p] = sr;
      op2_v[p] = 32'd1;
      run_txn(4'(1 << p));
      sr = sr / 2;
      total_cnt++;
      if (rsp_resp[p] !== 2'd1 || rsp_data[p] !== sr)
        $display("FAIL walk_shr step=%0d: got resp=%0d data=%h want resp=1 data=%h",
                 i, rsp_resp[p], rsp_data[p], sr);
      else pass_cnt++;
    end
  endtask

  task automatic test_idle_concurrent();
    logic [33:0] m;
    repeat (5) begin
      for (int p = 0; p < 4; p++) idle_port(p);
      @(negedge c_clk);
      for (int p = 0; p < 4; p++) begin
        total_cnt++;
        if (out_resp[p] !== 2'd0 || out_data[p] !== 32'd0)
          $display("FAIL idle_noise p%0d: got resp=%0d data=%h want resp=0 data=0",
                   p + 1, out_resp[p], out_data[p]);
        else pass_cnt++;
      end
    end
    for (int p = 0; p < 4; p++) begin
      cmd_v[p] = 4'd1;
      op1_v[p] = $urandom >> 1;
      op2_v[p] = $urandom >> 1;
    end
    run_txn(4'hF);
    for (int p = 0; p < 4; p++) begin
      m = model(cmd_v[p], op1_v[p], op2_v[p]);
      total_cnt++;
      if (rsp_resp[p] !== m[33:32] || rsp_data[p] !== m[31:0])
        $display("FAIL concurrent_add p%0d: got resp=%0d data=%h want resp=%0d data=%h",
                 p + 1, rsp_resp[p], rsp_data[p], m[33:32], m[31:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  cmd_b [4];
    logic [31:0] op1_b [4];
    logic [31:0] op2_b [4];
    logic [33:0] m;
    for (int t = 0; t < 4; t++) begin
      for (int p = 0; p < 4; p++) begin
        cmd_v[p] = rand_cmd(); op1_v[p] = rand_op(); op2_v[p] = rand_op();
        cmd_b[p] = rand_cmd(); op1_b[p] = rand_op(); op2_b[p] = rand_op();
      end
      drive_op1(4'hF);
      @(negedge c_clk);
      drive_op2(4'hF);
      @(negedge c_clk);
      for (int p = 0; p < 4; p++) begin
        m = model(cmd_v[p], op1_v[p], op2_v[p]);
        total_cnt++;
        if (out_resp[p] !== m[33:32] || out_data[p] !== m[31:0])
          $display("FAIL b2b_first p%0d: got resp=%0d data=%h want resp=%0d data=%h",
                   p + 1, out_resp[p], out_data[p], m[33:32], m[31:0]);
        else pass_cnt++;
        cmd_v[p] = cmd_b[p]; op1_v[p] = op1_b[p]; op2_v[p] = op2_b[p];
      end
      drive_op1(4'hF);
      @(negedge c_clk);
      for (int p = 0; p < 4; p++) begin
        total_cnt++;
        if (out_resp[p] !== 2'd0 || out_data[p] !== 32'd0)
          $display("FAIL b2b_gap p%0d: got resp=%0d data=%h want resp=0 data=0",
                   p + 1, out_resp[p], out_data[p]);
        else pass_cnt++;
      end
      drive_op2(4'hF);
      @(negedge c_clk);
      for (int p = 0; p < 4; p++) begin
        m = model(cmd_b[p], op1_b[p], op2_b[p]);
        total_cnt++;
        if (out_resp[p] !== m[33:32] || out_data[p] !== m[31:0])
          $display("FAIL b2b_second p%0d: got resp=%0d data=%h want resp=%0d data=%h",
                   p + 1, out_resp[p], out_data[p], m[33:32], m[31:0]);
        else pass_cnt++;
      end
      for (int p = 0; p < 4; p++) idle_port(p);
      @(negedge c_clk);
    end
  endtask

  task automatic test_random();
    logic [3:0]  mask;
    logic [33:0] m;
    for (int n = 0; n < 150; n++) begin
      mask = 4'($urandom_range(0, 15));
      for (int p = 0; p < 4; p++) begin
        cmd_v[p] = rand_cmd();
        op1_v[p] = rand_op();
        op2_v[p] = rand_op();
      end
      run_txn(mask);
      for (int p = 0; p < 4; p++) begin
        m = mask[p] ? model(cmd_v[p], op1_v[p], op2_v[p]) : 34'd0;
        total_cnt++;
        if (rsp_resp[p] !== m[33:32] || rsp_data[p] !== m[31:0])
          $display("FAIL random n=%0d p%0d cmd=%0d op1=%h op2=%h: got resp=%0d data=%h want resp=%0d data=%h",
                   n, p + 1, cmd_v[p], op1_v[p], op2_v[p], rsp_resp[p], rsp_data[p],
                   m[33:32], m[31:0]);
        else pass_cnt++;
        total_cnt++;
        if (post_resp[p] !== 2'd0 || post_data[p] !== 32'd0)
          $display("FAIL random_one_cycle n=%0d p%0d: got resp=%0d data=%h want resp=0 data=0",
                   n, p + 1, post_resp[p], post_data[p]);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_abort();
    test_add();
    test_overflow();
    test_underflow_invalid();
    test_walking();
    test_idle_concurrent();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
